// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
package lsu_pkg;

    localparam int         DATA_W         = 32;
    localparam logic [3:0] AXI_ID_DEFAULT = 4'd1;

    // Access size as carried on req_size; 11 behaves as a word access.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_D  = 3'd2,
        ST_WR_AW = 3'd3,
        ST_WR_B  = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_e;

    // Natural alignment check on the low address bits.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            default: misaligned = |off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_axi_if.sv
// Single-beat AXI4 data port between the LSU (master) and memory (slave).
interface lsu_axi_if;
    import lsu_pkg::*;

    logic [3:0]        arid;
    logic [DATA_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [3:0]        awid;
    logic [DATA_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/lsu_lane.sv
// Byte-lane steering: store replication/strobes and load extract/extend.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    input  logic [1:0]        off_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic [DATA_W-1:0] st_data_o,
    output logic [3:0]        st_strb_o,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [DATA_W-1:0] ld_shift;

    assign ld_shift = ld_data_i >> {off_i, 3'b000};

    // Word (and the reserved size) passes data straight through on all lanes.
    always_comb begin
        st_data_o = st_data_i;
        st_strb_o = 4'b1111;
        ld_data_o = ld_data_i;
        case (size_i)
            SZ_BYTE: begin
                st_data_o = {4{st_data_i[7:0]}};
                st_strb_o = 4'b0001 << off_i;
                ld_data_o = {{24{sign_i & ld_shift[7]}}, ld_shift[7:0]};
            end
            SZ_HALF: begin
                st_data_o = {2{st_data_i[15:0]}};
                st_strb_o = 4'b0011 << off_i;
                ld_data_o = {{16{sign_i & ld_shift[15]}}, ld_shift[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_axi.sv
// MEM-stage load/store unit: one outstanding single-beat AXI4 access.
module lsu_axi
    import lsu_pkg::*;
#(
    parameter logic [3:0] AXI_ID = AXI_ID_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              resp_adel,
    output logic              resp_ades,
    lsu_axi_if.master         axi
);

    lsu_state_e        state_q;
    logic [DATA_W-1:0] addr_q, wdata_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic              req_ready_q, arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic              resp_valid_q, resp_err_q, resp_adel_q, resp_ades_q;
    logic [DATA_W-1:0] resp_rdata_q;

    logic [1:0]        size_d;
    logic [DATA_W-1:0] st_wdata, ld_data;
    logic [3:0]        st_wstrb;

    // Reserved size folds into word so arsize/awsize are always legal.
    assign size_d = (req_size == SZ_RSVD) ? SZ_WORD : req_size;

    lsu_lane u_lane (
        .size_i    (size_q),
        .sign_i    (sign_q),
        .off_i     (addr_q[1:0]),
        .st_data_i (wdata_q),
        .ld_data_i (axi.rdata),
        .st_data_o (st_wdata),
        .st_strb_o (st_wstrb),
        .ld_data_o (ld_data)
    );

    // Control FSM; every handshake output is a register, never a ready->valid path.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= SZ_BYTE;
            sign_q       <= 1'b0;
            req_ready_q  <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            resp_adel_q  <= 1'b0;
            resp_ades_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        size_q      <= size_d;
                        sign_q      <= req_sign;
                        if (misaligned(size_d, req_addr[1:0])) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_err_q   <= 1'b1;
                            resp_adel_q  <= ~req_wr;
                            resp_ades_q  <= req_wr;
                        end else if (req_wr) begin
                            state_q   <= ST_WR_AW;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= ST_RD_A;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                ST_RD_A: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_D;
                    end
                end
                ST_RD_D: begin
                    if (axi.rvalid) begin
                        rready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= (axi.rresp != AXI_RESP_OKAY);
                        resp_rdata_q <= (axi.rresp == AXI_RESP_OKAY) ? ld_data : '0;
                        resp_adel_q  <= 1'b0;
                        resp_ades_q  <= 1'b0;
                        state_q      <= ST_RESP;
                    end
                end
                ST_WR_AW: begin
                    // AW and W retire independently; leave once neither is pending.
                    if (axi.awready) awvalid_q <= 1'b0;
                    if (axi.wready)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || axi.awready) && (!wvalid_q || axi.wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (axi.bvalid) begin
                        bready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= (axi.bresp != AXI_RESP_OKAY);
                        resp_rdata_q <= '0;
                        resp_adel_q  <= 1'b0;
                        resp_ades_q  <= 1'b0;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign resp_adel   = resp_adel_q;
    assign resp_ades   = resp_ades_q;

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = st_wdata;
    assign axi.wstrb   = st_wstrb;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

endmodule

// File: tb/tb_lsu_axi.sv
// Directed + randomized bench for lsu_axi with a cycle-level AXI slave.
module tb_lsu_axi;
    import lsu_pkg::*;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        req_valid = 1'b0, req_wr = 1'b0, req_sign = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, resp_adel, resp_ades;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    int          total = 0, passed = 0, failed = 0;

    lsu_axi_if axi();

    lsu_axi dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .resp_adel  (resp_adel),
        .resp_ades  (resp_ades),
        .axi        (axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    // Load result from the rules: pick n bytes at the offset, then extend.
    function automatic logic [31:0] model_load(input logic [1:0] s, input logic sg,
                                               input logic [31:0] a, input logic [31:0] d);
        int unsigned n, lim, v;
        n = nbytes(s);
        if (n == 4) return d;
        lim = 32'd1 << (8 * n);
        v = (d >> (8 * a[1:0])) % lim;
        if (sg && v >= lim / 2) v = v - lim;
        return v;
    endfunction

    task automatic slave_idle();
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 0; axi.rid = 4'd1; axi.rlast = 1;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = 4'd1;
    endtask

    task automatic run_txn(input string nm, input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ar_d, input int r_d, input int aw_d, input int w_d, input int b_d,
                           input logic [31:0] rd, input logic [1:0] rsp, input int hold);
        int n, off, k0, ar_k, aw_k, w_k, ar_n, r_n, aw_n, w_n, b_n, vld_n, lat;
        logic mis, stable, done, ld_ok, st_ok;
        logic [31:0] exp_rd, exp_wd, snap_rd;
        logic [3:0]  exp_strb, snap_f;
        logic [2:0]  exp_sz;
        n = nbytes(sz); off = addr % 4; mis = (addr % n) != 0;
        exp_sz = (n == 1) ? 3'd0 : (n == 2) ? 3'd1 : 3'd2;
        ld_ok = !wr && !mis; st_ok = wr && !mis;
        for (int i = 0; i < 4; i++) begin
            exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
            exp_strb[i] = (i >= off) && (i < off + n);
        end
        exp_rd = (ld_ok && rsp == 2'b00) ? model_load(sz, sg, addr, rd) : 32'd0;
        lat = mis ? 1 : wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + ar_d + r_d;

        @(negedge clk);
        slave_idle();
        chk({nm, ":req_ready_idle"}, req_ready, 1);
        req_valid = 1; req_wr = wr; req_size = sz; req_sign = sg; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        done = 0; k0 = -1; stable = 1; ar_k = 0; aw_k = 0; w_k = 0;
        ar_n = 0; r_n = 0; aw_n = 0; w_n = 0; b_n = 0; vld_n = 0;
        for (int k = 1; k <= 300 && !done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 0; resp_ready = 0;
                chk({nm, ":req_ready_busy"}, req_ready, 0);
            end
            axi.arready = (k > ar_d);
            axi.rvalid  = (ar_n > 0) && (r_n == 0) && (k >= ar_k + 1 + r_d);
            axi.rdata   = rd; axi.rresp = rsp;
            axi.awready = (k > aw_d);
            axi.wready  = (k > w_d);
            axi.bvalid  = (aw_n > 0) && (w_n > 0) && (b_n == 0) &&
                          (k >= ((aw_k > w_k) ? aw_k : w_k) + 1 + b_d);
            axi.bresp   = rsp;
            if (axi.arvalid || axi.awvalid || axi.wvalid) vld_n++;
            if (axi.arvalid && axi.arready) begin
                ar_n++; ar_k = k;
                chk({nm, ":araddr"}, axi.araddr, addr);
                chk({nm, ":arsize"}, axi.arsize, exp_sz);
                chk({nm, ":ar_len_burst_id"}, {axi.arlen, axi.arburst, axi.arid}, {8'd0, 2'b01, 4'd1});
            end
            if (axi.rvalid && axi.rready) r_n++;
            if (axi.awvalid && axi.awready) begin
                aw_n++; aw_k = k;
                chk({nm, ":awaddr"}, axi.awaddr, addr);
                chk({nm, ":awsize"}, axi.awsize, exp_sz);
                chk({nm, ":aw_len_burst_id"}, {axi.awlen, axi.awburst, axi.awid}, {8'd0, 2'b01, 4'd1});
            end
            if (axi.wvalid && axi.wready) begin
                w_n++; w_k = k;
                chk({nm, ":wdata"}, axi.wdata, exp_wd);
                chk({nm, ":wstrb_wlast"}, {axi.wstrb, axi.wlast}, {exp_strb, 1'b1});
            end
            if (axi.bvalid && axi.bready) b_n++;
            if (k0 >= 0 && !resp_valid) stable = 0;
            if (resp_valid) begin
                if (k0 < 0) begin
                    k0 = k; snap_rd = resp_rdata;
                    snap_f = {resp_valid, resp_err, resp_adel, resp_ades};
                    chk({nm, ":latency"}, k, lat);
                end else if (resp_rdata !== snap_rd ||
                             {resp_valid, resp_err, resp_adel, resp_ades} !== snap_f) stable = 0;
                resp_ready = (k - k0 >= hold);
                if (resp_ready) begin
                    done = 1;
                    chk({nm, ":rdata"}, resp_rdata, exp_rd);
                    chk({nm, ":err"}, resp_err, mis || (!mis && rsp != 2'b00));
                    chk({nm, ":adel_ades"}, {resp_adel, resp_ades}, {mis && !wr, mis && wr});
                    chk({nm, ":hs_ar_r_aw_w_b"}, {ar_n[3:0], r_n[3:0], aw_n[3:0], w_n[3:0], b_n[3:0]},
                        {4'(ld_ok), 4'(ld_ok), 4'(st_ok), 4'(st_ok), 4'(st_ok)});
                    if (mis) chk({nm, ":no_bus_valid"}, vld_n, 0);
                    if (hold > 0) chk({nm, ":resp_stable"}, stable, 1);
                end
            end
        end
        if (!done) begin
            chk({nm, ":timeout"}, 0, 1);
            resetn = 0; #1 resetn = 1;
        end
    endtask

    initial begin
        logic wr, sg;
        logic [1:0] sz, rsp;
        logic [31:0] addr;
        int n;
        slave_idle();
        repeat (2) @(negedge clk);
        chk("rst:req_ready", req_ready, 0);
        chk("rst:valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, resp_valid}, 0);
        chk("rst:resp", {resp_rdata, resp_err, resp_adel, resp_ades}, 0);
        resetn = 1;

        run_txn("ldw",   0, 2'b10, 0, 32'h1000, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00, 0);
        run_txn("ldbs",  0, 2'b00, 1, 32'h1003, 0, 0, 0, 0, 0, 0, 32'h80FF1234, 2'b00, 0);
        run_txn("ldbu",  0, 2'b00, 0, 32'h1003, 0, 0, 0, 0, 0, 0, 32'h80FF1234, 2'b00, 0);
        run_txn("sth",   1, 2'b01, 0, 32'h2002, 32'h0000ABCD, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        run_txn("ldmis", 0, 2'b10, 0, 32'h3001, 0, 0, 0, 0, 0, 0, 32'h11111111, 2'b00, 0);
        run_txn("stmis", 1, 2'b01, 0, 32'h3001, 32'h5555, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        run_txn("stslow", 1, 2'b10, 0, 32'h2100, 32'h12345678, 0, 0, 3, 0, 5, 0, 2'b10, 4);
        run_txn("ldhs_slv", 0, 2'b01, 1, 32'h4002, 0, 2, 3, 0, 0, 0, 32'h8001_7FFF, 2'b00, 2);
        run_txn("ldrsz", 0, 2'b11, 0, 32'h4004, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 2'b00, 0);
        run_txn("ldslverr", 0, 2'b10, 0, 32'h4008, 0, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 2'b10, 0);

        // Reset while waiting for read data.
        @(negedge clk);
        chk("rstmid:req_ready", req_ready, 1);
        req_valid = 1; req_wr = 0; req_size = 2'b10; req_sign = 0; req_addr = 32'h5000;
        @(negedge clk);
        req_valid = 0; axi.arready = 1;
        @(negedge clk);
        axi.arready = 0; axi.rvalid = 0;
        chk("rstmid:rready_in_rd_d", axi.rready, 1);
        #2 resetn = 0;
        #1;
        chk("rstmid:async_drop", {axi.arvalid, axi.rready, resp_valid, req_ready}, 0);
        @(negedge clk);
        resetn = 1;
        run_txn("ld_after_rst", 0, 2'b10, 0, 32'h5000, 0, 0, 0, 0, 0, 0, 32'h0BADF00D, 2'b00, 0);

        for (int t = 0; t < 40; t++) begin
            wr = $urandom_range(0, 1); sz = $urandom_range(0, 3); sg = $urandom_range(0, 1);
            n = nbytes(sz);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr - (addr % n);
            rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn($sformatf("rnd%0d", t), wr, sz, sg, addr, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom, rsp, $urandom_range(0, 2));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lsu_axi.md
# lsu_axi

Load/store unit for the MEM stage of the pipelined MIPS core. It takes the effective address computed by the EX-stage ALU together with the store data, issues a single-beat AXI4 read or write on the data port, and returns aligned, sign- or zero-extended load data (or a store completion) to write-back. Misaligned accesses are rejected locally with an address-error flag and never reach the bus.

## Interface
- DATA_W, 32, data and address width; fixed at 32.
- AXI_ID, 4'd1, constant ARID/AWID driven on every transaction.
- clk  in  1  core clock; all AXI signals are synchronous to it.
- resetn  in  1  asynchronous, active-low reset.
- req_valid / req_ready  in / out  1  request handshake from EX.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  effective address (ALU result y).
- req_wdata  in  32  store data, right-justified.
- resp_valid / resp_ready  out / in  1  completion handshake to WB.
- resp_rdata  out  32  extended load data; 0 for stores and on error.
- resp_err  out  1  misaligned access or non-OKAY AXI response.
- resp_adel / resp_ades  out  1  misaligned load / store (subset of resp_err).
- AXI read: arid, araddr, arlen (0), arsize, arburst (01 INCR), arvalid, arready; rid, rdata, rresp, rlast, rvalid, rready.
- AXI write: awid, awaddr, awlen (0), awsize, awburst (01), awvalid, awready; wdata, wstrb, wlast (1), wvalid, wready; bid, bresp, bvalid, bready.

## Operation
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, RESP.
- IDLE: req_ready=1. On req_valid, register addr/size/sign/wr/wdata. Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> RESP with err=1 and adel/ades set. Otherwise a load goes to RD_A, a store goes to WR_AW.
- RD_A: arvalid=1, araddr=full addr, arsize=req_size. On arready -> RD_D.
- RD_D: rready=1. On rvalid, capture rdata/rresp -> RESP.
- WR_AW: awvalid and wvalid both assert on entry and each drops independently after its own handshake. The handshakes may occur in either order or in the same cycle. Once both are done -> WR_B.
- WR_B: bready=1. On bvalid, capture bresp -> RESP.
- RESP: resp_valid=1, held stable until resp_ready -> IDLE.
- Load extraction: shift rdata right by 8*addr[1:0]; byte/half are extended per req_sign; word is passed through.
- Store lanes: byte replicated 4x, wstrb = 0001<<addr[1:0]. Half replicated 2x, wstrb = 0011<<addr[1:0]. Word uses wstrb=1111.
- rresp/bresp != 00 -> resp_err=1, resp_rdata=0, adel/ades=0.

## Timing
- Reset values: all valid/ready outputs 0 except that req_ready rises in IDLE after reset release; resp_* = 0; state IDLE.
- Reset mid-transaction aborts immediately and drops all valids. No bus completion is guaranteed, because a system reset is assumed.
- Minimum latency (accept edge -> resp_valid) with zero-wait slave: 3 cycles for a load (RD_A, RD_D, RESP) and 3 for a store (WR_AW, WR_B, RESP). Misaligned access: 1 cycle.
- Only one outstanding transaction; req_ready=0 from acceptance until the RESP handshake.
- arvalid/awvalid/wvalid never depend combinationally on the ready inputs; address, data and size stay stable while valid.
- resp_ready=0 in RESP stalls the unit indefinitely with outputs stable.

## Structure
- lsu_pkg: size encodings, AXI_BURST_INCR, AXI_RESP_OKAY, FSM state encodings, AXI_ID default.
- Sub-module lsu_lane is purely combinational. It produces the store wdata/wstrb from size, addr[1:0] and data, and the load extraction/extension from size, sign, addr[1:0] and rdata.
- The top level holds the FSM, request registers and response registers.

## Test plan
- Word load at 0x1000 with zero-wait slave returning 0xDEADBEEF -> araddr 0x1000, arsize 10, resp_rdata 0xDEADBEEF, resp_err 0, resp_valid 3 cycles after accept.
- Signed byte load at 0x1003, rdata 0x80FF1234 -> resp_rdata 0xFFFFFF80. The same access unsigned -> 0x00000080.
- Half store of 0x0000ABCD at 0x2002 -> wdata 0xABCDABCD, wstrb 1100, awsize 01. bresp OKAY gives resp_err 0 and resp_rdata 0.
- Word load at 0x3001 -> no arvalid, resp_valid after 1 cycle with resp_err=1, resp_adel=1. Half store at 0x3001 -> resp_ades=1.
- Store with wready asserted 3 cycles before awready, then bvalid delayed 5 cycles with bresp=10 -> exactly one W and one AW handshake, resp_err=1. Holding resp_ready=0 for 4 cycles keeps resp_* stable.
- resetn pulled low while in RD_D -> arvalid/rready/resp_valid go 0 asynchronously; after release, a new load completes normally.
